note_sequencer: RTL
===================

# note_sequencer

Plays a stored melody by sequencing the period input of the square-wave I2S tone path. Holds a small writable table of (period, duration) entries, steps through it one note at a time with durations counted in audio frames (lrclk periods), and drives `period` plus a `mute` gate to the tone generator. Sits between a host or ROM loader and the clock-divider/I2S chain.

## Interface
- `WIDTH`, 16, width of a note period (matches the tone generator period input)
- `DUR_W`, 8, width of a note duration in lrclk frames
- `DEPTH`, 16, number of table entries (power of two); `AW = log2(DEPTH)`

- `clk`  in  1  system clock (same clock as the I2S block)
- `reset`  in  1  asynchronous, active-low reset
- `lrclk`  in  1  frame clock from the I2S block, synchronous to `clk`
- `start`  in  1  one-cycle request to play from entry 0
- `stop`  in  1  one-cycle request to abort playback
- `loop`  in  1  level: at end of table/sequence, restart at entry 0 instead of finishing
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  AW  table write address
- `wr_data`  in  WIDTH+DUR_W  entry: `{period, dur}`
- `period`  out  WIDTH  current note period to the tone generator
- `mute`  out  1  1 = force silence (tone path outputs midscale/zero)
- `note_idx`  out  AW  index of the entry currently playing
- `busy`  out  1  high from LOAD through PLAY/GAP
- `done`  out  1  one-cycle pulse when a non-looping sequence ends

## Operation
- Entry encoding: `dur == 0` ends the sequence; `period == 0` with `dur != 0` is a rest (mute=1 for its duration).
- Frame tick: `tick = lrclk & ~lrclk_q` (rising-edge detect, registered `lrclk_q`).
- FSM states: IDLE, LOAD, PLAY, GAP, DONE.
  - IDLE: mute=1, busy=0. `start` -> LOAD with idx=0, table read issued.
  - LOAD: read data valid. If `dur==0` -> DONE (or LOAD at idx 0 if `loop` and idx≠0; empty table with `loop` -> DONE). Else latch period, set mute=(period==0), count=dur -> PLAY.
  - PLAY: on each tick, count decrements. On the tick where count==1, advance: next idx = idx+1; if idx was DEPTH-1, next idx wraps to 0 and, when `loop`=0, go DONE. Otherwise -> GAP (if enabled) or LOAD.
  - GAP: mute=1 for one tick, then LOAD.
  - DONE: done=1 for one cycle, mute=1, -> IDLE.
- `stop` in any state -> IDLE next cycle, mute=1, period held; `stop` wins over simultaneous `start`.
- `start` while busy: ignored.
- Table writes allowed any time; a write to the address being read in the same cycle returns old data; new data is used at that address's next LOAD.

## Timing
- Reset values: period=0, mute=1, note_idx=0, busy=0, done=0, state IDLE, count=0, lrclk_q=0.
- `start` at cycle N -> LOAD at N+1 -> period/mute valid and busy=1 at N+2.
- tick asserts one cycle after the lrclk rising edge; a note of duration D occupies exactly D frame ticks in PLAY.
- Note-to-note changeover (no gap): 2 clk cycles of LOAD with the previous period held, mute unchanged.
- `done` asserts the cycle after DONE is entered for exactly one cycle.
- Reset asserted mid-note: all outputs return to reset values immediately (asynchronous); table contents undefined/not cleared.

## Configuration
- `NOTESEQ_GAP_EN`: defined -> GAP state compiled in, one muted frame between consecutive notes (articulation). Undefined -> GAP absent, PLAY goes directly to LOAD; notes are legato.

## Structure
- Package `noteseq_pkg`: state encoding constants (IDLE, LOAD, PLAY, GAP, DONE), entry field positions (`dur` in low DUR_W bits, `period` above).
- Sub-module `noteseq_ram`: DEPTH x (WIDTH+DUR_W) single-write-port, single-read-port RAM with one-cycle synchronous read, read-before-write.

## Test plan
- Load {90,3},{120,2},{0,0}; start -> period=90 for 3 ticks, period=120 for 2 ticks, done pulse once, mute=1, busy=0.
- Entry {0,4} between notes -> mute=1 for 4 ticks, period change not audible; busy stays 1.
- loop=1 with {90,1},{0,0} -> period=90 repeats indefinitely, done never asserts, note_idx toggles 0→1→0 (LOAD only).
- stop asserted during 2nd tick of a 5-tick note -> next cycle IDLE, mute=1, busy=0; start together with stop in IDLE -> stays IDLE.
- All 16 entries nonzero, loop=0 -> after entry 15, note_idx wraps to 0 and done pulses; with `NOTESEQ_GAP_EN` each changeover shows exactly one muted tick.
- Reset low mid-PLAY -> period=0, mute=1, busy=0, note_idx=0 asynchronously; start after release replays from entry 0.

Source files
------------

// File: rtl/note_sequencer_pkg.sv
// Shared sizes, FSM state encoding and table-entry field layout for the note sequencer.
package noteseq_pkg;
    localparam int WIDTH      = 16;
    localparam int DUR_W      = 8;
    localparam int DEPTH      = 16;
    localparam int AW         = $clog2(DEPTH);
    localparam int ENTRY_W    = WIDTH + DUR_W;
    localparam int DUR_LSB    = 0;
    localparam int PERIOD_LSB = DUR_W;

    localparam logic [AW-1:0]    IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    IDX_LAST = {AW{1'b1}};
    localparam logic [DUR_W-1:0] DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] entry);
        return entry[DUR_LSB +: DUR_W];
    endfunction

    function automatic logic [WIDTH-1:0] entry_period(input logic [ENTRY_W-1:0] entry);
        return entry[PERIOD_LSB +: WIDTH];
    endfunction
endpackage

// File: rtl/note_sequencer_if.sv
// Host/loader-side bus of the note sequencer: control, table write port and tone-path outputs.
interface note_sequencer_if;
    import noteseq_pkg::*;

    logic               lrclk;
    logic               start;
    logic               stop;
    logic               loop;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [ENTRY_W-1:0] wr_data;
    logic [WIDTH-1:0]   period;
    logic               mute;
    logic [AW-1:0]      note_idx;
    logic               busy;
    logic               done;

    modport master (
        output lrclk, start, stop, loop, wr_en, wr_addr, wr_data,
        input  period, mute, note_idx, busy, done
    );

    modport slave (
        input  lrclk, start, stop, loop, wr_en, wr_addr, wr_data,
        output period, mute, note_idx, busy, done
    );
endinterface

// File: rtl/note_sequencer_ram.sv
// Note table: DEPTH x ENTRY_W, one write port, one synchronous read port, read-before-write.
module noteseq_ram
    import noteseq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);
    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [ENTRY_W-1:0] rd_data_r;

    // Table storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register sees the pre-write contents on an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {ENTRY_W{1'b0}};
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;
endmodule

// File: rtl/note_sequencer.sv
// Steps through the note table one entry per note, counting durations in lrclk frames.
// Build option: define NOTESEQ_GAP_EN to insert one muted frame between consecutive notes.
module note_sequencer
    import noteseq_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    note_sequencer_if.slave bus
);
    state_t             state_r;
    logic               load_wait_r;
    logic [AW-1:0]      idx_r;
    logic [DUR_W-1:0]   count_r;
    logic [WIDTH-1:0]   period_r;
    logic               mute_r;
    logic               busy_r;
    logic               done_r;
    logic               lrclk_q_r;
    logic               tick_s;
    logic [ENTRY_W-1:0] rd_data_s;
    logic [DUR_W-1:0]   rd_dur_s;
    logic [WIDTH-1:0]   rd_period_s;

    // The table is always read at idx_r; IDLE parks idx_r at 0 so start finds entry 0 ready.
    noteseq_ram u_ram (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (idx_r),
        .rd_data (rd_data_s)
    );

    assign rd_dur_s    = entry_dur(rd_data_s);
    assign rd_period_s = entry_period(rd_data_s);
    assign tick_s      = bus.lrclk & ~lrclk_q_r;

    // Frame-clock edge detector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lrclk_q_r <= 1'b0;
        end else begin
            lrclk_q_r <= bus.lrclk;
        end
    end

    // Sequencer FSM with registered outputs; load_wait_r marks a stale read after idx_r moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            load_wait_r <= 1'b0;
            idx_r       <= {AW{1'b0}};
            count_r     <= {DUR_W{1'b0}};
            period_r    <= {WIDTH{1'b0}};
            mute_r      <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else if (bus.stop) begin
            state_r     <= ST_IDLE;
            load_wait_r <= 1'b0;
            idx_r       <= {AW{1'b0}};
            mute_r      <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    idx_r  <= {AW{1'b0}};
                    mute_r <= 1'b1;
                    if (bus.start) begin
                        state_r     <= ST_LOAD;
                        load_wait_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_wait_r) begin
                        load_wait_r <= 1'b0;
                    end else if (rd_dur_s == {DUR_W{1'b0}}) begin
                        if (bus.loop && (idx_r != {AW{1'b0}})) begin
                            idx_r       <= {AW{1'b0}};
                            load_wait_r <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            idx_r   <= {AW{1'b0}};
                            mute_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r  <= ST_PLAY;
                        period_r <= rd_period_s;
                        mute_r   <= (rd_period_s == {WIDTH{1'b0}});
                        count_r  <= rd_dur_s;
                    end
                end
                ST_PLAY: begin
                    if (tick_s) begin
                        if (count_r == DUR_ONE) begin
                            count_r <= {DUR_W{1'b0}};
                            idx_r   <= idx_r + IDX_ONE;
                            if ((idx_r == IDX_LAST) && !bus.loop) begin
                                state_r <= ST_DONE;
                                mute_r  <= 1'b1;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end else begin
`ifdef NOTESEQ_GAP_EN
                                state_r <= ST_GAP;
                                mute_r  <= 1'b1;
`else
                                state_r     <= ST_LOAD;
                                load_wait_r <= 1'b1;
`endif
                            end
                        end else begin
                            count_r <= count_r - DUR_ONE;
                        end
                    end
                end
`ifdef NOTESEQ_GAP_EN
                ST_GAP: begin
                    if (tick_s) begin
                        state_r     <= ST_LOAD;
                        load_wait_r <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    mute_r  <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    load_wait_r <= 1'b0;
                    idx_r       <= {AW{1'b0}};
                    mute_r      <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.period   = period_r;
    assign bus.mute     = mute_r;
    assign bus.note_idx = idx_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
endmodule
